calculation_divide: RTL and testbench
=====================================

CALCULATION_DIVIDE -- requirements
Module: calculation_divide

Interface
REQ-001 The block SHALL have exactly one clock and one reset. The reset SHALL be synchronous and active-high.
REQ-002 div_clk  input  1  clock; all state updates SHALL occur on its rising edge.
REQ-003 div_rst  input  1  synchronous active-high reset.
REQ-004 div_start  input  1  request to start a division; sampled only when div_busy=0.
REQ-005 div_a  input  8  unsigned dividend; sampled on the accepting edge.
REQ-006 div_b  input  4  unsigned divisor; sampled on the accepting edge.
REQ-007 div_q  output  8  unsigned quotient; registered.
REQ-008 div_r  output  4  unsigned remainder; registered.
REQ-009 div_busy  output  1  high while a division is in progress; registered.
REQ-010 div_done  output  1  one-cycle pulse marking div_q, div_r and div_err as valid; registered.
REQ-011 div_err  output  1  divide-by-zero flag; valid with div_done.

Function
REQ-012 The block SHALL be the inverse operator of the team's 4x4 multiplier: div_a = div_q*div_b + div_r, with div_r < div_b, for every div_b != 0.
REQ-013 The FSM SHALL have three states:
- IDLE
- RUN
- DONE
REQ-014 Acceptance from IDLE:
- condition: div_start=1 and div_b!=0 on a rising edge;
- action: latch the operands, clear the iteration counter and the 5-bit partial remainder, go to RUN, set div_busy=1.
REQ-015 RUN SHALL perform one restoring-division step per cycle:
- shift the partial remainder left by one, bringing in the next dividend bit (MSB first);
- subtract the divisor when partial remainder >= divisor;
- shift the resulting quotient bit in;
- a 3-bit counter SHALL track the 8 steps.
REQ-016 On the 8th RUN edge the FSM SHALL:
- go to DONE;
- load div_q and div_r;
- set div_done=1, div_err=0, div_busy=0.
REQ-017 Latency: div_done SHALL be high in the cycle following the 8th rising edge after the accepting edge, which is 8 cycles after acceptance.
REQ-018 DONE SHALL last exactly one cycle, after which div_done returns to 0. If div_start=1 in DONE, the division SHALL be accepted exactly as from IDLE (back-to-back operation). Otherwise the FSM SHALL go to IDLE.
REQ-019 div_q, div_r and div_err SHALL hold their values until the next completion or reset.
REQ-020 div_start asserted while div_busy=1 SHALL be ignored. Changes on div_a and div_b during RUN SHALL have no effect.
REQ-021 Divide by zero: div_start=1 with div_b=0 SHALL skip RUN and go directly to DONE on the accepting edge. In the next cycle the outputs SHALL be:
- div_q=8'hFF;
- div_r=div_a[3:0];
- div_err=1;
- div_done=1;
- div_busy=0.
REQ-022 The partial remainder SHALL be 5 bits internally so the comparison never overflows. div_r SHALL be its low 4 bits.

Reset
REQ-023 div_rst=1 on a rising edge SHALL force IDLE and clear everything from any state, including mid-RUN:
- div_q=0, div_r=0;
- div_busy=0, div_done=0, div_err=0;
- the counter and the partial remainder.
REQ-024 A division interrupted by reset SHALL produce no div_done.
REQ-025 div_start asserted during the same edge as div_rst=1 SHALL be ignored.

Verification
REQ-026 Scenario 1: reset, then start with div_a=28, div_b=4 -> div_done 8 cycles later; div_q=7, div_r=0, div_err=0.
REQ-027 Scenario 2: start with div_a=200, div_b=7 -> div_q=28, div_r=4. Then div_start=1 in the DONE cycle with div_a=255, div_b=1 -> second div_done 8 cycles later with div_q=255, div_r=0.
REQ-028 Scenario 3: start with div_a=5, div_b=9 -> div_q=0, div_r=5. Pulse div_start again mid-RUN with different operands -> it is ignored and the result is unchanged.
REQ-029 Scenario 4: start with div_a=100, div_b=0 -> div_done one cycle later with div_q=8'hFF, div_r=4, div_err=1. A following 14/3 clears div_err and gives div_q=4, div_r=2.
REQ-030 Scenario 5: start with div_a=99, div_b=5, then assert div_rst at RUN step 4 -> all outputs 0 and no div_done. A fresh 99/5 then gives div_q=19, div_r=4.
REQ-031 Exhaustive check: all 256x16 operand pairs SHALL be compared against a reference model (a/b, a%b, and the REQ-021 rule for b=0).

Source files
------------

// File: rtl/calculation_divide.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle.
// Divide-by-zero skips the iteration and reports q=FF, r=a[3:0], err=1.
module calculation_divide (
  input  logic       div_clk,
  input  logic       div_rst,
  input  logic       div_start,
  input  logic [7:0] div_a,
  input  logic [3:0] div_b,
  output logic [7:0] div_q,
  output logic [3:0] div_r,
  output logic       div_busy,
  output logic       div_done,
  output logic       div_err,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_dividend;
  logic [3:0] r_divisor;
  logic [4:0] r_prem;
  logic [7:0] r_quo;
  logic [2:0] r_cnt;

  logic [4:0] w_shift;
  logic       w_ge;
  logic [4:0] w_prem_next;
  logic [7:0] w_quo_next;

  // Partial remainder stays below the divisor, so the shifted value fits in 5 bits.
  assign w_shift     = (r_prem << 1) | {4'd0, r_dividend[7]};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_prem_next = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
  assign w_quo_next  = {r_quo[6:0], w_ge};

  assign o_dbg_state = r_state;

  always_ff @(posedge div_clk) begin
    if (div_rst) begin
      r_state    <= S_IDLE;
      r_dividend <= 8'd0;
      r_divisor  <= 4'd0;
      r_prem     <= 5'd0;
      r_quo      <= 8'd0;
      r_cnt      <= 3'd0;
      div_q      <= 8'd0;
      div_r      <= 4'd0;
      div_busy   <= 1'b0;
      div_done   <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          div_done <= 1'b0;
          if (div_start) begin
            if (div_b != 4'd0) begin
              r_state    <= S_RUN;
              r_dividend <= div_a;
              r_divisor  <= div_b;
              r_prem     <= 5'd0;
              r_quo      <= 8'd0;
              r_cnt      <= 3'd0;
              div_busy   <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              div_q    <= 8'hFF;
              div_r    <= div_a[3:0];
              div_err  <= 1'b1;
              div_done <= 1'b1;
              div_busy <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_prem     <= w_prem_next;
          r_quo      <= w_quo_next;
          r_dividend <= {r_dividend[6:0], 1'b0};
          r_cnt      <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state  <= S_DONE;
            div_q    <= w_quo_next;
            div_r    <= w_prem_next[3:0];
            div_done <= 1'b1;
            div_err  <= 1'b0;
            div_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculation_divide.sv
// Bench for calculation_divide: directed scenarios plus an exhaustive sweep
// with random start/operand activity while the divider is busy.
module tb_calculation_divide;

  logic       div_clk = 1'b0;
  logic       div_rst;
  logic       div_start;
  logic [7:0] div_a;
  logic [3:0] div_b;
  logic [7:0] div_q;
  logic [3:0] div_r;
  logic       div_busy;
  logic       div_done;
  logic       div_err;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  calculation_divide dut (
    .div_clk    (div_clk),
    .div_rst    (div_rst),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_q      (div_q),
    .div_r      (div_r),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_err    (div_err),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 div_clk = ~div_clk;

  // Reference model: {err, q, r}
  function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] q;
    logic [7:0] rr;
    if (b == 4'd0) return {1'b1, 8'hFF, a[3:0]};
    q  = a / {4'd0, b};
    rr = a % {4'd0, b};
    return {1'b0, q, rr[3:0]};
  endfunction

  // Driver: called at a negedge, leaves at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    div_a     = a;
    div_b     = b;
    div_start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge div_clk);
    div_start = 1'b0;
  endtask

  // Bounded wait for div_done; optional random stimulus noise while waiting.
  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    while (div_done !== 1'b1 && lat < 20) begin
      if (noise) begin
        div_start = 1'($urandom_range(0, 1));
        div_a     = 8'($urandom_range(0, 255));
        div_b     = 4'($urandom_range(0, 15));
      end
      @(negedge div_clk);
      lat++;
    end
    div_start = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    div_rst = 1'b1; div_start = 1'b0; div_a = 8'd0; div_b = 4'd0;
    repeat (2) @(negedge div_clk);
    checks++;
    if ({div_q, div_r, div_busy, div_done, div_err} !== 15'd0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b err=%0b st=%0d want all 0",
               div_q, div_r, div_busy, div_done, div_err, o_dbg_state);
    end
    div_start = 1'b1; div_a = 8'd50; div_b = 4'd5;
    @(negedge div_clk);
    div_rst = 1'b0; div_start = 1'b0;
    checks++;
    if (div_busy !== 1'b0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%0b st=%0d want busy=0 st=0", div_busy, o_dbg_state);
    end
    seen = 0;
    repeat (12) begin
      @(negedge div_clk);
      if (div_done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_start_no_done: got %0d done cycles want 0", seen);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [12:0] exp;
    start_op(8'd28, 4'd4);
    checks++;
    if (div_busy !== 1'b1 || o_dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL basic_busy: got busy=%0b st=%0d want busy=1 st=1", div_busy, o_dbg_state);
    end
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({div_err, div_q, div_r} !== exp || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got err=%0b q=%0d r=%0d busy=%0b want err=%0b q=%0d r=%0d busy=0",
               div_err, div_q, div_r, div_busy, exp[12], exp[11:4], exp[3:0]);
    end
    @(negedge div_clk);
    checks++;
    if (div_done !== 1'b0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%0b st=%0d want done=0 st=0", div_done, o_dbg_state);
    end
    div_a = 8'd3; div_b = 4'd2;
    repeat (3) @(negedge div_clk);
    checks++;
    if ({div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL basic_hold: got err=%0b q=%0d r=%0d want err=%0b q=%0d r=%0d",
               div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [12:0] exp;
    start_op(8'd200, 4'd7);
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 8 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d err=%0b q=%0d r=%0d want lat=8 err=%0b q=%0d r=%0d",
               lat, div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
    start_op(8'd255, 4'd1);
    checks++;
    if (div_busy !== 1'b1 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b done=%0b want busy=1 done=0", div_busy, div_done);
    end
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 8 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d err=%0b q=%0d r=%0d want lat=8 err=%0b q=%0d r=%0d",
               lat, div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
    @(negedge div_clk);
  endtask

  task automatic test_ignore_busy();
    int lat;
    int seen;
    logic [12:0] exp;
    start_op(8'd5, 4'd9);
    repeat (3) @(negedge div_clk);
    div_start = 1'b1; div_a = 8'd200; div_b = 4'd3;
    @(negedge div_clk);
    div_start = 1'b0;
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 4 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL ignore_result: got lat=%0d err=%0b q=%0d r=%0d want lat=4 err=%0b q=%0d r=%0d",
               lat, div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
    seen = 0;
    repeat (12) begin
      @(negedge div_clk);
      if (div_done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL ignore_no_second: got %0d extra done q=%0d r=%0d want 0 extra q=%0d r=%0d",
               seen, div_q, div_r, exp[11:4], exp[3:0]);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [12:0] exp;
    start_op(8'd100, 4'd0);
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 0 || {div_err, div_q, div_r} !== exp || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_result: got lat=%0d err=%0b q=%0d r=%0d busy=%0b want lat=0 err=%0b q=%0d r=%0d busy=0",
               lat, div_err, div_q, div_r, div_busy, exp[12], exp[11:4], exp[3:0]);
    end
    @(negedge div_clk);
    start_op(8'd14, 4'd3);
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 8 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL divzero_recover: got lat=%0d err=%0b q=%0d r=%0d want lat=8 err=%0b q=%0d r=%0d",
               lat, div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
    @(negedge div_clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    logic [12:0] exp;
    div_a = 8'd99; div_b = 4'd5; div_start = 1'b1;
    @(negedge div_clk);
    div_start = 1'b0;
    repeat (3) @(negedge div_clk);
    div_rst = 1'b1;
    @(negedge div_clk);
    div_rst = 1'b0;
    checks++;
    if ({div_q, div_r, div_busy, div_done, div_err} !== 15'd0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midrun_reset: got q=%0d r=%0d busy=%0b done=%0b err=%0b st=%0d want all 0",
               div_q, div_r, div_busy, div_done, div_err, o_dbg_state);
    end
    seen = 0;
    repeat (12) begin
      @(negedge div_clk);
      if (div_done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done cycles want 0", seen);
    end
    start_op(8'd99, 4'd5);
    wait_done(1'b0, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 8 || {div_err, div_q, div_r} !== exp) begin
      errors++;
      $display("FAIL midrun_fresh: got lat=%0d err=%0b q=%0d r=%0d want lat=8 err=%0b q=%0d r=%0d",
               lat, div_err, div_q, div_r, exp[12], exp[11:4], exp[3:0]);
    end
    @(negedge div_clk);
  endtask

  task automatic test_exhaustive();
    int lat;
    int want_lat;
    logic [12:0] exp;
    for (int i = 0; i < 4096; i++) begin
      start_op(8'(i >> 4), 4'(i));
      want_lat = ((i & 15) == 0) ? 0 : 8;
      wait_done(1'b1, lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== want_lat || {div_err, div_q, div_r} !== exp) begin
        errors++;
        $display("FAIL exhaustive a=%0d b=%0d: got lat=%0d err=%0b q=%0d r=%0d want lat=%0d err=%0b q=%0d r=%0d",
                 i >> 4, i & 15, lat, div_err, div_q, div_r, want_lat, exp[12], exp[11:4], exp[3:0]);
      end
    end
    @(negedge div_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_div_zero();
    test_reset_mid_run();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
